// File: rtl/mem_sized_port_if.sv
// mem_sized_port_if
//   Valid/ready request bus plus single-pulse response for mem_sized_port.
//   Signals:
//     req_valid   request present (master -> slave)
//     req_ready   slave can accept this cycle (slave -> master)
//     req_we      1 = write, 0 = read
//     req_size    00 byte, 01 halfword, 10 word, 11 illegal
//     req_addr    byte address
//     req_wdata   write data, LSB-aligned
//     resp_valid  one-cycle completion pulse
//     resp_rdata  read data, zero-extended; 0 for writes and errors
//     resp_err    access rejected, qualified by resp_valid
//   Modports: master (load/store unit side), slave (memory side).
interface mem_sized_port_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid, req_we, req_size, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_we, req_size, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/mem_sized_port.sv
// mem_sized_port
//   Single-port, byte-addressed, little-endian memory with byte/halfword/word
//   accesses, programmable wait states and a range/size error response.
//   Ports:
//     clk    in  clock, all state updates on posedge
//     rst_n  in  asynchronous active-low reset (array contents are kept)
//     bus    slave side of mem_sized_port_if (request + response)
//   Parameters:
//     BASE_ADDR    first byte address decoded by this instance
//     DEPTH        size in bytes, power of two, >= 4
//     WAIT_STATES  extra cycles between accept and response, 0..15
//   Build option:
//     MEM_ALIGN_CHECK_EN  defined   -> misaligned halfword/word gives resp_err
//                         undefined -> offset is force-aligned to the access size
module mem_sized_port #(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned DEPTH       = 65536,
    parameter int unsigned WAIT_STATES = 0
) (
    input logic             clk,
    input logic             rst_n,
    mem_sized_port_if.slave bus
);
    localparam int unsigned AW        = $clog2(DEPTH);
    localparam logic [3:0]  WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_t;

    state_t         state;
    logic [3:0]     wait_cnt;

    logic           acc_we;
    logic [1:0]     acc_size;
    logic [AW-1:0]  acc_off;
    logic           acc_err;
    logic [31:0]    acc_wdata;

    logic [7:0]     mem [DEPTH];

    function automatic logic [2:0] size_bytes(input logic [1:0] sz);
        case (sz)
            2'b00:   size_bytes = 3'd1;
            2'b01:   size_bytes = 3'd2;
            default: size_bytes = 3'd4;
        endcase
    endfunction

    // Decode of the live request; only consumed while IDLE.
    logic [31:0] dec_off_raw;
    logic [31:0] dec_off;
    logic [32:0] dec_end;
    logic        dec_err;

    always_comb begin
        dec_off_raw = bus.req_addr - BASE_ADDR;
        dec_off     = dec_off_raw;
        dec_err     = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
        if (bus.req_size == 2'b01 && bus.req_addr[0])
            dec_err = 1'b1;
        if (bus.req_size == 2'b10 && bus.req_addr[1:0] != 2'b00)
            dec_err = 1'b1;
`else
        if (bus.req_size == 2'b01)
            dec_off[0] = 1'b0;
        else if (bus.req_size == 2'b10)
            dec_off[1:0] = 2'b00;
`endif
        // 33-bit end so an offset near 2^32 cannot wrap into range.
        dec_end = {1'b0, dec_off} + {30'd0, size_bytes(bus.req_size)};
        if (bus.req_size == 2'b11)
            dec_err = 1'b1;
        if (dec_end > 33'(DEPTH))
            dec_err = 1'b1;
    end

    // With zero wait states RESP is entered on the accept edge, so the
    // response is built from the live decode; otherwise from the capture.
    logic          sel_we;
    logic [1:0]    sel_size;
    logic [AW-1:0] sel_off;
    logic          sel_err;
    logic [31:0]   rd_next;

    always_comb begin
        if (state == ST_IDLE) begin
            sel_we   = bus.req_we;
            sel_size = bus.req_size;
            sel_off  = dec_off[AW-1:0];
            sel_err  = dec_err;
        end else begin
            sel_we   = acc_we;
            sel_size = acc_size;
            sel_off  = acc_off;
            sel_err  = acc_err;
        end

        case (sel_size)
            2'b00:   rd_next = {24'd0, mem[sel_off]};
            2'b01:   rd_next = {16'd0, mem[sel_off + AW'(1)], mem[sel_off]};
            default: rd_next = {mem[sel_off + AW'(3)], mem[sel_off + AW'(2)],
                                mem[sel_off + AW'(1)], mem[sel_off]};
        endcase
        if (sel_we || sel_err)
            rd_next = 32'd0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= ST_IDLE;
            wait_cnt       <= 4'd0;
            acc_we         <= 1'b0;
            acc_size       <= 2'b00;
            acc_off        <= '0;
            acc_err        <= 1'b0;
            acc_wdata      <= 32'd0;
            bus.req_ready  <= 1'b1;
            bus.resp_valid <= 1'b0;
            bus.resp_rdata <= 32'd0;
            bus.resp_err   <= 1'b0;
        end else begin
            bus.resp_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.req_valid) begin
                        acc_we        <= bus.req_we;
                        acc_size      <= bus.req_size;
                        acc_off       <= dec_off[AW-1:0];
                        acc_err       <= dec_err;
                        acc_wdata     <= bus.req_wdata;
                        bus.req_ready <= 1'b0;
                        if (WAIT_STATES > 0) begin
                            state    <= ST_WAIT;
                            wait_cnt <= WAIT_LOAD;
                        end else begin
                            state          <= ST_RESP;
                            bus.resp_valid <= 1'b1;
                            bus.resp_rdata <= rd_next;
                            bus.resp_err   <= sel_err;
                        end
                    end
                end
                ST_WAIT: begin
                    if (wait_cnt == 4'd0) begin
                        state          <= ST_RESP;
                        bus.resp_valid <= 1'b1;
                        bus.resp_rdata <= rd_next;
                        bus.resp_err   <= sel_err;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                ST_RESP: begin
                    state          <= ST_IDLE;
                    bus.req_ready  <= 1'b1;
                    bus.resp_rdata <= 32'd0;
                    bus.resp_err   <= 1'b0;
                end
                default: begin
                    state         <= ST_IDLE;
                    bus.req_ready <= 1'b1;
                end
            endcase
        end
    end

    // Write commits on the edge that closes RESP; a reset during WAIT or
    // RESP forces IDLE first, so an aborted access never reaches the array.
    always_ff @(posedge clk) begin
        if (state == ST_RESP && acc_we && !acc_err) begin
            mem[acc_off] <= acc_wdata[7:0];
            if (acc_size != 2'b00)
                mem[acc_off + AW'(1)] <= acc_wdata[15:8];
            if (acc_size == 2'b10) begin
                mem[acc_off + AW'(2)] <= acc_wdata[23:16];
                mem[acc_off + AW'(3)] <= acc_wdata[31:24];
            end
        end
    end
endmodule

// File: tb/tb_mem_sized_port.sv
// tb_mem_sized_port
//   Directed bench for mem_sized_port. Four instances share one request
//   driver; t_sel picks which one sees req_valid and whose response is read.
//     0: BASE 0,           DEPTH 256, WAIT_STATES 0
//     1: BASE 0,           DEPTH 256, WAIT_STATES 3
//     2: BASE 0,           DEPTH 256, WAIT_STATES 2
//     3: BASE 32'h2000_0000, DEPTH 256, WAIT_STATES 0
module tb_mem_sized_port;
`ifdef MEM_ALIGN_CHECK_EN
    localparam bit ALIGN_CHK = 1'b1;
`else
    localparam bit ALIGN_CHK = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int          t_sel = 0;
    logic        t_valid = 1'b0;
    logic        t_we = 1'b0;
    logic [1:0]  t_size = 2'b00;
    logic [31:0] t_addr = 32'd0;
    logic [31:0] t_wdata = 32'd0;

    logic        r_ready, r_valid, r_err;
    logic [31:0] r_rdata;

    int n_tests = 0;
    int n_fail  = 0;

    mem_sized_port_if if0 ();
    mem_sized_port_if if1 ();
    mem_sized_port_if if2 ();
    mem_sized_port_if if3 ();

    assign if0.req_valid = t_valid && (t_sel == 0);
    assign if1.req_valid = t_valid && (t_sel == 1);
    assign if2.req_valid = t_valid && (t_sel == 2);
    assign if3.req_valid = t_valid && (t_sel == 3);
    assign if0.req_we = t_we;    assign if0.req_size = t_size;
    assign if0.req_addr = t_addr; assign if0.req_wdata = t_wdata;
    assign if1.req_we = t_we;    assign if1.req_size = t_size;
    assign if1.req_addr = t_addr; assign if1.req_wdata = t_wdata;
    assign if2.req_we = t_we;    assign if2.req_size = t_size;
    assign if2.req_addr = t_addr; assign if2.req_wdata = t_wdata;
    assign if3.req_we = t_we;    assign if3.req_size = t_size;
    assign if3.req_addr = t_addr; assign if3.req_wdata = t_wdata;

    mem_sized_port #(.BASE_ADDR(32'h0000_0000), .DEPTH(256), .WAIT_STATES(0))
        u_ws0 (.clk(clk), .rst_n(rst_n), .bus(if0.slave));
    mem_sized_port #(.BASE_ADDR(32'h0000_0000), .DEPTH(256), .WAIT_STATES(3))
        u_ws3 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));
    mem_sized_port #(.BASE_ADDR(32'h0000_0000), .DEPTH(256), .WAIT_STATES(2))
        u_ws2 (.clk(clk), .rst_n(rst_n), .bus(if2.slave));
    mem_sized_port #(.BASE_ADDR(32'h2000_0000), .DEPTH(256), .WAIT_STATES(0))
        u_base (.clk(clk), .rst_n(rst_n), .bus(if3.slave));

    always_comb begin
        r_ready = 1'b0;
        r_valid = 1'b0;
        r_rdata = 32'd0;
        r_err   = 1'b0;
        case (t_sel)
            0: begin r_ready = if0.req_ready; r_valid = if0.resp_valid;
                     r_rdata = if0.resp_rdata; r_err = if0.resp_err; end
            1: begin r_ready = if1.req_ready; r_valid = if1.resp_valid;
                     r_rdata = if1.resp_rdata; r_err = if1.resp_err; end
            2: begin r_ready = if2.req_ready; r_valid = if2.resp_valid;
                     r_rdata = if2.resp_rdata; r_err = if2.resp_err; end
            default: begin r_ready = if3.req_ready; r_valid = if3.resp_valid;
                     r_rdata = if3.resp_rdata; r_err = if3.resp_err; end
        endcase
    end

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic int ws_of(input int sel);
        case (sel)
            1:       ws_of = 3;
            2:       ws_of = 2;
            default: ws_of = 0;
        endcase
    endfunction

    // Entered and left at #1 after a posedge with the selected DUT idle.
    task automatic access(input int sel, input logic we, input logic [1:0] size,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input bit scramble,
                          output logic [31:0] rdata, output logic err,
                          output int lat, output int busy, output int pulses);
        int n;
        t_sel = sel; t_we = we; t_size = size; t_addr = addr; t_wdata = wdata;
        n = 0;
        while (!r_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check_eq("ready_before_req", 32'(r_ready), 32'd1);
        t_valid = 1'b1;
        @(posedge clk); #1;
        t_valid = 1'b0;
        if (scramble) begin
            t_we = ~we; t_size = 2'b00; t_addr = addr ^ 32'h4; t_wdata = ~wdata;
        end
        rdata = 32'hxxxx_xxxx; err = 1'bx;
        lat = 0; busy = 0; pulses = 0;
        for (int c = 1; c <= 40; c++) begin
            if (r_valid) begin
                pulses++;
                if (lat == 0) begin
                    lat = c; rdata = r_rdata; err = r_err;
                end
            end
            if (r_ready) break;
            busy++;
            @(posedge clk); #1;
        end
    endtask

    task automatic do_wr(input string tag, input int sel, input logic [1:0] size,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic exp_err, input bit scramble);
        logic [31:0] rd; logic er; int lat, busy, pulses;
        access(sel, 1'b1, size, addr, wdata, scramble, rd, er, lat, busy, pulses);
        check_eq({tag, "_err"},    32'(er),     32'(exp_err));
        check_eq({tag, "_rdata"},  rd,          32'd0);
        check_eq({tag, "_lat"},    32'(lat),    32'(ws_of(sel) + 1));
        check_eq({tag, "_busy"},   32'(busy),   32'(ws_of(sel) + 1));
        check_eq({tag, "_pulses"}, 32'(pulses), 32'd1);
    endtask

    task automatic do_rd(input string tag, input int sel, input logic [1:0] size,
                         input logic [31:0] addr, input logic [31:0] exp_data,
                         input logic exp_err, input bit scramble);
        logic [31:0] rd; logic er; int lat, busy, pulses;
        access(sel, 1'b0, size, addr, 32'h5A5A_5A5A, scramble, rd, er, lat, busy, pulses);
        check_eq({tag, "_err"},    32'(er),     32'(exp_err));
        check_eq({tag, "_rdata"},  rd,          exp_data);
        check_eq({tag, "_lat"},    32'(lat),    32'(ws_of(sel) + 1));
        check_eq({tag, "_pulses"}, 32'(pulses), 32'd1);
    endtask

    localparam logic [1:0] SZ_B = 2'b00, SZ_H = 2'b01, SZ_W = 2'b10, SZ_X = 2'b11;
    localparam logic [31:0] T1_ADDR = ALIGN_CHK ? 32'h0000_00F8 : 32'h0000_00FA;

    initial begin
        int pulses;

        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_ready", 32'(if0.req_ready),  32'd1);
        check_eq("rst_valid", 32'(if0.resp_valid), 32'd0);
        check_eq("rst_rdata", if0.resp_rdata,      32'd0);
        check_eq("rst_err",   32'(if0.resp_err),   32'd0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // basic word write/read, zero wait states
        do_wr("t1_wr", 0, SZ_W, T1_ADDR, 32'h98BA_DCFF, 1'b0, 1'b0);
        do_rd("t1_rd", 0, SZ_W, T1_ADDR, 32'h98BA_DCFF, 1'b0, 1'b0);

        // lane isolation; upper wdata bits must not leak into other lanes
        do_wr("t2_w0",  0, SZ_W, 32'h00, 32'hCAFE_F00D, 1'b0, 1'b0);
        do_wr("t2_w",   0, SZ_W, 32'h10, 32'h1122_3344, 1'b0, 1'b0);
        do_wr("t2_b",   0, SZ_B, 32'h11, 32'h1234_56AA, 1'b0, 1'b0);
        do_wr("t2_h",   0, SZ_H, 32'h12, 32'h7777_BEEF, 1'b0, 1'b0);
        do_rd("t2_rw",  0, SZ_W, 32'h10, 32'hBEEF_AA44, 1'b0, 1'b0);
        do_rd("t2_rb",  0, SZ_B, 32'h13, 32'h0000_00BE, 1'b0, 1'b0);
        do_rd("t2_rh",  0, SZ_H, 32'h12, 32'h0000_BEEF, 1'b0, 1'b0);

        // range / size / alignment errors, DEPTH 256
        do_wr("t4_fc",   0, SZ_W, 32'hFC, 32'h0102_0304, 1'b0, 1'b0);
        do_rd("t4_fc_r", 0, SZ_W, 32'hFC, 32'h0102_0304, 1'b0, 1'b0);
        do_wr("t4_fe",   0, SZ_W, 32'hFE, 32'h5566_7788, ALIGN_CHK, 1'b0);
        do_rd("t4_fe_r", 0, SZ_W, 32'hFC, ALIGN_CHK ? 32'h0102_0304 : 32'h5566_7788, 1'b0, 1'b0);
        do_rd("t4_ff_b", 0, SZ_B, 32'hFF, ALIGN_CHK ? 32'h0000_0001 : 32'h0000_0055, 1'b0, 1'b0);
        do_wr("t4_100",  0, SZ_W, 32'h100, 32'h9999_9999, 1'b1, 1'b0);
        do_rd("t4_100r", 0, SZ_W, 32'h100, 32'h0, 1'b1, 1'b0);
        do_rd("t4_nowr", 0, SZ_W, 32'h00, 32'hCAFE_F00D, 1'b0, 1'b0);
        do_rd("t4_sz_r", 0, SZ_X, 32'h10, 32'h0, 1'b1, 1'b0);
        do_wr("t4_sz_w", 0, SZ_X, 32'h10, 32'h0, 1'b1, 1'b0);
        do_rd("t4_sz_c", 0, SZ_W, 32'h10, 32'hBEEF_AA44, 1'b0, 1'b0);
        do_rd("t4_wrap", 0, SZ_H, 32'hFFFF_FFFE, 32'h0, 1'b1, 1'b0);

        // three wait states, request inputs scrambled while busy
        do_wr("t3_wr", 1, SZ_W, 32'h40, 32'hA5A5_0F0F, 1'b0, 1'b1);
        do_rd("t3_rd", 1, SZ_W, 32'h40, 32'hA5A5_0F0F, 1'b0, 1'b1);

        // reset while in WAIT aborts the write
        do_wr("t5_prior", 2, SZ_W, 32'h20, 32'h1234_5678, 1'b0, 1'b0);
        t_sel = 2; t_we = 1'b1; t_size = SZ_W; t_addr = 32'h20; t_wdata = 32'hDEAD_BEEF;
        t_valid = 1'b1;
        @(posedge clk); #1;
        t_valid = 1'b0;
        check_eq("t5_in_wait", 32'(r_ready), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        check_eq("t5_rst_ready", 32'(r_ready), 32'd1);
        check_eq("t5_rst_valid", 32'(r_valid), 32'd0);
        check_eq("t5_rst_rdata", r_rdata,      32'd0);
        pulses = 0;
        repeat (3) begin
            @(posedge clk); #1;
            if (r_valid) pulses++;
        end
        @(negedge clk) rst_n = 1'b1;
        repeat (4) begin
            @(posedge clk); #1;
            if (r_valid) pulses++;
        end
        check_eq("t5_no_resp", 32'(pulses), 32'd0);
        do_rd("t5_rd", 2, SZ_W, 32'h20, 32'h1234_5678, 1'b0, 1'b0);

        // nonzero base address
        do_rd("t6_below", 3, SZ_W, 32'h1FFF_FFFF, 32'h0, 1'b1, 1'b0);
        do_wr("t6_wr",    3, SZ_W, 32'h2000_0000, 32'h0BAD_C0DE, 1'b0, 1'b0);
        do_rd("t6_rb",    3, SZ_B, 32'h2000_0001, 32'h0000_00C0, 1'b0, 1'b0);
        do_rd("t6_rw",    3, SZ_W, 32'h2000_0000, 32'h0BAD_C0DE, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
        $fatal(1);
    end
endmodule
